// File: rtl/frame_filter_controller.sv
// Frame-synchronous configurator for the pixel filter chain: tracks the video
// handshake and commits filter select / debounced freq_flag only at frame ends.
module frame_filter_controller #(
  parameter int NUM_FILTERS  = 4,
  parameter int SEL_W        = 2,
  parameter int HOLD_FRAMES  = 2,
  parameter int CYCLE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sop_in,
  input  logic                   eop_in,
  input  logic                   valid_in,
  input  logic                   ready_in,
  input  logic [1:0]             freq_flag_in,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   auto_mode_in,
  output logic [NUM_FILTERS-1:0] use_flags_out,
  output logic [1:0]             freq_flag_out,
  output logic                   in_frame_out,
  output logic [CNT_W-1:0]       frame_count_out,
  output logic                   frame_err_out
);

  localparam int ST_W = $clog2(HOLD_FRAMES + 1);
  localparam int CY_W = $clog2(CYCLE_FRAMES + 1);

  typedef enum logic [1:0] {S_WAIT, S_IN, S_BOUND} state_t;

  state_t                 state_q;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [NUM_FILTERS-1:0] use_q, use_d;
  logic [1:0]             freq_q, freq_d, cand_q, cand_d, freq_norm;
  logic [ST_W-1:0]        stable_q, stable_d;
  logic [CY_W-1:0]        cycle_q, cycle_d;
  logic [CNT_W-1:0]       count_q;
  logic                   in_frame_q, err_q;
  logic                   beat;

  assign beat = valid_in & ready_in;

  // Candidate commit values; only applied during the BOUNDARY cycle.
  always_comb begin
    freq_norm = (freq_flag_in == 2'd3) ? 2'd2 : freq_flag_in;
    if (freq_norm == cand_q) begin
      cand_d   = cand_q;
      stable_d = (stable_q == ST_W'(HOLD_FRAMES)) ? stable_q : stable_q + 1'b1;
    end else begin
      cand_d   = freq_norm;
      stable_d = ST_W'(1);
    end
    freq_d = (stable_d == ST_W'(HOLD_FRAMES)) ? cand_d : freq_q;

    sel_d   = sel_q;
    cycle_d = cycle_q;
    if (!auto_mode_in) begin
      if (int'(sel_in) < NUM_FILTERS) sel_d = sel_in;
      cycle_d = '0;
    end else if (cycle_q == CY_W'(CYCLE_FRAMES - 1)) begin
      cycle_d = '0;
      sel_d   = (sel_q == SEL_W'(NUM_FILTERS - 1)) ? '0 : sel_q + 1'b1;
    end else begin
      cycle_d = cycle_q + 1'b1;
    end

    use_d        = '0;
    use_d[sel_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      sel_q      <= '0;
      use_q      <= NUM_FILTERS'(1);
      freq_q     <= '0;
      cand_q     <= '0;
      stable_q   <= '0;
      cycle_q    <= '0;
      count_q    <= '0;
      in_frame_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == S_BOUND) begin
        sel_q    <= sel_d;
        use_q    <= use_d;
        freq_q   <= freq_d;
        cand_q   <= cand_d;
        stable_q <= stable_d;
        cycle_q  <= cycle_d;
        count_q  <= count_q + 1'b1;
      end
      case (state_q)
        S_IN: begin
          if (beat && eop_in) begin
            state_q    <= S_BOUND;
            in_frame_q <= 1'b0;
          end else if (beat && sop_in) begin
            err_q <= 1'b1;
          end
        end
        // BOUNDARY behaves like WAIT_SOP for beats, but never lingers.
        default: begin
          state_q    <= S_WAIT;
          in_frame_q <= 1'b0;
          if (beat) begin
            if (sop_in && !eop_in) begin
              state_q    <= S_IN;
              in_frame_q <= 1'b1;
            end else if (sop_in && eop_in) begin
              state_q <= S_BOUND;
            end else if (eop_in) begin
              err_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign use_flags_out   = use_q;
  assign freq_flag_out   = freq_q;
  assign in_frame_out    = in_frame_q;
  assign frame_count_out = count_q;
  assign frame_err_out   = err_q;

endmodule
